// File: rtl/clk_rst_seq_pkg.sv
// Shared types and constants for the PLL-lock driven reset sequencer.
package clk_rst_seq_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      HOLD      = 2'd1,
      RELEASE   = 2'd2,
      RUN       = 2'd3
   } state_e;

   localparam int LOCK_CNT_W = 8;
   localparam logic [LOCK_CNT_W-1:0] LOCK_CNT_MAX = '1;

endpackage

// File: rtl/clk_rst_seq_if.sv
// Lock input, soft-reset request and sequenced reset/status outputs of clk_rst_seq.
interface clk_rst_seq_if #(
   parameter int N_DOMAINS = 3
) ();
   import clk_rst_seq_pkg::*;

   logic                  pll_locked;
   logic                  soft_rst_req;
   logic [N_DOMAINS-1:0]  rst_n_out;
   logic                  ready;
   logic [LOCK_CNT_W-1:0] lock_loss_cnt;

   modport master (
      output pll_locked, soft_rst_req,
      input  rst_n_out, ready, lock_loss_cnt
   );

   modport slave (
      input  pll_locked, soft_rst_req,
      output rst_n_out, ready, lock_loss_cnt
   );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser with asynchronous active-low clear.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         q      <= 1'b0;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end

endmodule

// File: rtl/clk_rst_seq.sv
// Releases per-domain resets in order once the PLL has been stably locked,
// and pulls them all back on lock loss or a soft reset request.
module clk_rst_seq
   import clk_rst_seq_pkg::*;
#(
   parameter int N_DOMAINS   = 3,
   parameter int HOLD_CYCLES = 16,
   parameter int STAGE_GAP   = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   clk_rst_seq_if.slave  bus
);

   localparam logic [N_DOMAINS-1:0] FIRST     = N_DOMAINS'(1);
   localparam logic [15:0]          HOLD_LAST = 16'(HOLD_CYCLES - 1);
   localparam logic [7:0]           GAP_LAST  = 8'(STAGE_GAP - 1);

   logic                  locked_s;
   state_e                state_q, state_d;
   logic [15:0]           hold_cnt_q, hold_cnt_d;
   logic [7:0]            gap_cnt_q, gap_cnt_d;
   logic [N_DOMAINS-1:0]  rst_out_q, rst_out_d;
   logic                  ready_q, ready_d;
   logic [LOCK_CNT_W-1:0] loss_cnt_q, loss_cnt_d;

   sync_2ff u_lock_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (bus.pll_locked),
      .q     (locked_s)
   );

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      rst_out_d  = rst_out_q;
      ready_d    = ready_q;
      loss_cnt_d = loss_cnt_q;
      unique case (state_q)
         WAIT_LOCK: begin
            if (locked_s) begin
               state_d    = HOLD;
               hold_cnt_d = '0;
            end
         end
         HOLD: begin
            hold_cnt_d = hold_cnt_q + 16'd1;
            if (!locked_s) begin
               state_d = WAIT_LOCK;
            end else if (hold_cnt_q == HOLD_LAST) begin
               rst_out_d = FIRST;
               gap_cnt_d = '0;
               if (N_DOMAINS == 1) begin
                  state_d = RUN;
                  ready_d = 1'b1;
               end else begin
                  state_d = RELEASE;
               end
            end
         end
         RELEASE: begin
            gap_cnt_d = gap_cnt_q + 8'd1;
            if (!locked_s) begin
               state_d   = WAIT_LOCK;
               rst_out_d = '0;
            end else if (gap_cnt_q == GAP_LAST) begin
               // Released domains form a thermometer code: bit 0 up first.
               gap_cnt_d = '0;
               rst_out_d = (rst_out_q << 1) | FIRST;
               if (rst_out_d[N_DOMAINS-1]) begin
                  state_d = RUN;
                  ready_d = 1'b1;
               end
            end
         end
         RUN: begin
            // Lock loss wins over a coincident soft request so it is counted.
            if (!locked_s || bus.soft_rst_req) begin
               state_d   = WAIT_LOCK;
               rst_out_d = '0;
               ready_d   = 1'b0;
               if (!locked_s && loss_cnt_q != LOCK_CNT_MAX)
                  loss_cnt_d = loss_cnt_q + LOCK_CNT_W'(1);
            end
         end
         default: state_d = WAIT_LOCK;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= WAIT_LOCK;
         hold_cnt_q <= '0;
         gap_cnt_q  <= '0;
         rst_out_q  <= '0;
         ready_q    <= 1'b0;
         loss_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         rst_out_q  <= rst_out_d;
         ready_q    <= ready_d;
         loss_cnt_q <= loss_cnt_d;
      end
   end

   assign bus.rst_n_out     = rst_out_q;
   assign bus.ready         = ready_q;
   assign bus.lock_loss_cnt = loss_cnt_q;

endmodule
